// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if
//   Handshake and operand bundle for seq_multiplier.
//   start  : launch request (master -> slave)
//   a, b   : multiplicand / multiplier, WIDTH bits (master -> slave)
//   sgn    : two's-complement mode select, present only when
//            SEQ_MULT_SIGNED_EN is defined (master -> slave)
//   busy   : high while the multiplier is iterating (slave -> master)
//   done   : one-cycle completion pulse (slave -> master)
//   p      : registered 2*WIDTH-bit product (slave -> master)
interface seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     p;
`ifdef SEQ_MULT_SIGNED_EN
  logic                   sgn;

  modport master (output start, a, b, sgn, input busy, done, p);
  modport slave  (input start, a, b, sgn, output busy, done, p);
`else
  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
`endif
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Sequential shift-and-add multiplier: one WIDTH+1-bit adder iterated over
//   WIDTH cycles, with a start/busy/done handshake and a registered product.
//   Optional macro SEQ_MULT_SIGNED_EN adds a sgn input selecting
//   two's-complement operands (sign-extended partial sums, final iteration
//   subtracts the multiplicand).
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : seq_multiplier_if.slave (start, a, b, [sgn], busy, done, p)
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_multiplier_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     mult_reg;
  logic [WIDTH-1:0]     acc_hi_reg;
  logic [WIDTH-1:0]     acc_lo_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 sgn_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [2*WIDTH-1:0]   p_reg;

  logic                 sgn_in;
  logic                 last;
  logic [WIDTH:0]       acc_ext;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       sum_next;

`ifdef SEQ_MULT_SIGNED_EN
  assign sgn_in = bus.sgn;
`else
  assign sgn_in = 1'b0;
`endif

  assign last = (cnt_reg == CW'(WIDTH - 1));

  // The extra top bit holds the carry in unsigned mode and the sign copy in
  // signed mode; in both cases it becomes the new accumulator MSB after the
  // right shift, so one datapath serves both.
  always_comb begin
    acc_ext  = {sgn_reg & acc_hi_reg[WIDTH-1], acc_hi_reg};
    addend   = mult_reg[0] ? {sgn_reg & mcand_reg[WIDTH-1], mcand_reg}
                           : '0;
    // Multiplier MSB carries negative weight in two's complement.
    sum_next = (sgn_reg && last) ? (acc_ext - addend) : (acc_ext + addend);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mult_reg   <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      cnt_reg    <= '0;
      sgn_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      p_reg      <= '0;
    end else begin
      case (state_reg)
        // DONE shares IDLE's accept path so back-to-back starts lose no cycle.
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            mcand_reg  <= bus.a;
            mult_reg   <= bus.b;
            sgn_reg    <= sgn_in;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end else begin
            state_reg  <= IDLE;
          end
        end
        RUN: begin
          acc_hi_reg <= sum_next[WIDTH:1];
          acc_lo_reg <= {sum_next[0], acc_lo_reg[WIDTH-1:1]};
          mult_reg   <= mult_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last) begin
            // Product taken straight from this cycle's shifted sum so p is
            // written exactly once per operation.
            p_reg     <= {sum_next, acc_lo_reg[WIDTH-1:1]};
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.p    = p_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier
//   Table-driven check of seq_multiplier at WIDTH=4 plus hand-written
//   sequences: ignored start during RUN, reset mid-RUN, result hold, and a
//   WIDTH=8 back-to-back run with start held high.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(4)) b4 ();
  seq_multiplier_if #(.WIDTH(8)) b8 ();

  seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sgn;
    logic [7:0] exp_p;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge. Returns after done is seen (or the bound expires).
  // lat counts negedges from the accept edge to the done cycle.
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] p, output int lat, output int busyc);
    b4.a     = a;
    b4.b     = b;
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    lat   = 0;
    busyc = 0;
    while (!b4.done && lat < 20) begin
      if (b4.busy) busyc++;
      @(negedge clk);
      lat++;
    end
    p = b4.p;
  endtask

  initial begin
    logic [7:0]  p4;
    logic [15:0] p16;
    int          lat, busyc, n, dcount, t1, t2;

    b4.start = 1'b0; b4.a = '0; b4.b = '0;
    b8.start = 1'b0; b8.a = '0; b8.b = '0;
`ifdef SEQ_MULT_SIGNED_EN
    b4.sgn = 1'b0;
    b8.sgn = 1'b0;
`endif

    vecs.push_back('{4'd15, 4'd15, 1'b0, 8'd225});
    vecs.push_back('{4'd0,  4'd9,  1'b0, 8'd0});
    vecs.push_back('{4'd9,  4'd0,  1'b0, 8'd0});
    vecs.push_back('{4'd6,  4'd7,  1'b0, 8'd42});
    vecs.push_back('{4'd1,  4'd1,  1'b0, 8'd1});
    vecs.push_back('{4'd8,  4'd7,  1'b0, 8'd56});
    vecs.push_back('{4'd13, 4'd11, 1'b0, 8'd143});
`ifdef SEQ_MULT_SIGNED_EN
    vecs.push_back('{4'b1000, 4'd7,    1'b1, 8'hC8});
    vecs.push_back('{4'b1000, 4'b1000, 1'b1, 8'd64});
    vecs.push_back('{4'hF,    4'hF,    1'b1, 8'd1});
    vecs.push_back('{4'd3,    4'hE,    1'b1, 8'hFA});
    vecs.push_back('{4'hF,    4'hF,    1'b0, 8'd225});
`endif

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy4", 64'(b4.busy), 64'd0);
    check("reset done4", 64'(b4.done), 64'd0);
    check("reset p4",    64'(b4.p),    64'd0);
    check("reset p8",    64'(b8.p),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    foreach (vecs[i]) begin
`ifdef SEQ_MULT_SIGNED_EN
      b4.sgn = vecs[i].sgn;
`endif
      run4(vecs[i].a, vecs[i].b, p4, lat, busyc);
      $display("[TB] vec %0d: a=%0d b=%0d sgn=%0d -> p=0x%0h (exp 0x%0h) lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].sgn, p4, vecs[i].exp_p, lat);
      check("latency",     64'(lat),   64'd4);
      check("busy cycles", 64'(busyc), 64'd4);
      check("product",     64'(p4),    64'(vecs[i].exp_p));
      @(negedge clk);
      check("done width",  64'(b4.done), 64'd0);
      check("p hold",      64'(b4.p),    64'(vecs[i].exp_p));
    end
`ifdef SEQ_MULT_SIGNED_EN
    b4.sgn = 1'b0;
`endif

    // p holds across idle cycles until the next accepted start
    repeat (5) @(negedge clk);
    check("p idle hold", 64'(b4.p), 64'(vecs[vecs.size()-1].exp_p));
    check("busy idle",   64'(b4.busy), 64'd0);

    // start pulsed 2 cycles into RUN is ignored
    b4.a = 4'd6; b4.b = 4'd7; b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    n = 0;
    repeat (2) begin @(negedge clk); n++; end
    b4.a = 4'd1; b4.b = 4'd1; b4.start = 1'b1;
    @(negedge clk); n++;
    b4.start = 1'b0;
    while (!b4.done && n < 20) begin @(negedge clk); n++; end
    $display("[TB] ignore-start: 6*7 -> p=%0d lat=%0d", b4.p, n);
    check("ignore lat", 64'(n),    64'd4);
    check("ignore p",   64'(b4.p), 64'd42);
    @(negedge clk);
    @(negedge clk);
    check("no relaunch", 64'(b4.busy), 64'd0);

    // Reset 2 cycles into RUN: outputs clear at once, no done afterwards
    b4.a = 4'd13; b4.b = 4'd11; b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] reset mid-run: busy=%0d done=%0d p=%0d", b4.busy, b4.done, b4.p);
    check("rst busy", 64'(b4.busy), 64'd0);
    check("rst done", 64'(b4.done), 64'd0);
    check("rst p",    64'(b4.p),    64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (b4.done || b4.busy) dcount++;
    end
    check("no done after rst", 64'(dcount), 64'd0);
    check("p after rst",       64'(b4.p),   64'd0);

    // WIDTH=8 back-to-back, start held high
    b8.a = 8'd255; b8.b = 8'd255; b8.start = 1'b1;
    n = 0;
    @(negedge clk); n++;
    while (!b8.done && n < 40) begin @(negedge clk); n++; end
    t1 = n;
    p16 = b8.p;
    b8.a = 8'd16; b8.b = 8'd16;
    $display("[TB] b2b #1: 255*255 -> p=%0d at %0d", p16, t1);
    check("b2b first p",   64'(p16), 64'd65025);
    check("b2b first lat", 64'(t1),  64'd9);
    @(negedge clk); n++;
    check("b2b relaunch", 64'(b8.busy), 64'd1);
    while (!b8.done && n < 60) begin @(negedge clk); n++; end
    t2 = n;
    b8.start = 1'b0;
    p16 = b8.p;
    $display("[TB] b2b #2: 16*16 -> p=%0d at %0d", p16, t2);
    check("b2b second p", 64'(p16),     64'd256);
    check("b2b spacing",  64'(t2 - t1), 64'd9);
    @(negedge clk);
    @(negedge clk);
    check("b2b stop", 64'(b8.busy), 64'd0);
    check("b2b hold", 64'(b8.p),    64'd256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
